// File: rtl/hex_display_scanner.sv
// Multiplexed common-anode 7-segment viewer for wide debug words.
// Shadows a DATA_W word, pages it DIGITS nibbles at a time, and scans the page with guard blanking.
module hex_display_scanner #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned PAGE_W      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 2,
    parameter int unsigned SCROLL_DIV  = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic [PAGE_W-1:0] page,
    input  logic              auto_scroll,
    input  logic              blank,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              dp,
    output logic [PAGE_W-1:0] cur_page
);

    localparam int unsigned NUM_PAGES = DATA_W / (4 * DIGITS);
    localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SCR_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SCR_W-1:0]  scr_q, scr_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic              auto_q, auto_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;

    logic              page_ok;
    logic              off;
    int unsigned       nib_sel;
    logic [DATA_W-1:0] shifted;
    logic [3:0]        nibble;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign page_ok = (32'(page_q) < NUM_PAGES);

    // Refresh slot counter and digit index.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Page selection: manual follows the input, auto advances on the scroll timer.
    always_comb begin
        scr_d  = scr_q;
        page_d = page_q;
        auto_d = auto_scroll;
        if (!auto_scroll) begin
            scr_d  = '0;
            page_d = page;
        end else if (!auto_q) begin
            scr_d  = '0;
            page_d = page_ok ? page_q : '0;
        end else if (scr_q == SCR_W'(SCROLL_DIV - 1)) begin
            scr_d  = '0;
            page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
        end else begin
            scr_d  = scr_q + 1'b1;
        end
    end

    assign shadow_d = load ? data : shadow_q;

    // Digit k of page p is nibble p*DIGITS + DIGITS-1-k counted from the MSB end.
    always_comb begin
        nib_sel = 32'(page_q) * DIGITS + (DIGITS - 1) - 32'(idx_q);
        shifted = shadow_q << (4 * nib_sel);
        nibble  = shifted[DATA_W-1 -: 4];
    end

    always_comb begin
        off   = blank || (32'(cnt_q) < GUARD) || !page_ok;
        an_d  = off ? '1 : ~(DIGITS'(1) << idx_q);
        seg_d = off ? 7'h7F : hex2seg(nibble);
        dp_d  = !(auto_scroll && !off && (idx_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            scr_q    <= '0;
            page_q   <= '0;
            auto_q   <= 1'b0;
            seg_q    <= 7'h7F;
            an_q     <= '1;
            dp_q     <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            scr_q    <= scr_d;
            page_q   <= page_d;
            auto_q   <= auto_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;
    assign cur_page = page_q;

endmodule
